dpu_rf_wb: RTL

Write-back and hazard-tracking front end for the DPU register file. It accepts results from the ALU and LSU pipes over valid/ready channels and registers them onto the two register-file write ports. It keeps a per-register busy scoreboard set at issue and cleared at write-back. It answers rs1/rs2 hazard queries with a forward path covering the cycle in which a write is on the RF ports but not yet in the array.

---
 rtl/dpu_rf_wb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dpu_rf_wb.sv
// Register-file write-back front end: two registered write stages (ALU, LSU),
// a per-register busy scoreboard, and rs1/rs2 hazard/forward queries.
module dpu_rf_wb #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int RF_DEPTH      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_hold_i,
    input  logic                     alu_vld_i,
    output logic                     alu_rdy_o,
    input  logic [RF_ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic                     lsu_vld_i,
    output logic                     lsu_rdy_o,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]          lsu_data_i,
    input  logic                     iss_vld_i,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rd_i,
    input  logic [RF_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [RF_ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic                     rs1_fwd_vld_o,
    output logic                     rs2_fwd_vld_o,
    output logic [XLEN-1:0]          rs1_fwd_data_o,
    output logic [XLEN-1:0]          rs2_fwd_data_o,
    output logic                     dpu2rf_wr0_o,
    output logic [RF_ADDR_WIDTH-1:0] dpu2rf_waddr0_o,
    output logic [XLEN-1:0]          dpu2rf_wdata0_o,
    output logic                     dpu2rf_wr1_o,
    output logic [RF_ADDR_WIDTH-1:0] dpu2rf_waddr1_o,
    output logic [XLEN-1:0]          dpu2rf_wdata1_o,
    output logic                     idle_o
);

    localparam int NPORT = 2;
    localparam int NQRY  = 2;

    logic                     collision;
    logic [NPORT-1:0]         in_vld;
    logic [NPORT-1:0]         in_rdy;
    logic [NPORT-1:0]         xfer;
    logic [RF_ADDR_WIDTH-1:0] in_addr [NPORT];
    logic [XLEN-1:0]          in_data [NPORT];

    logic [NPORT-1:0]         wr;
    logic [RF_ADDR_WIDTH-1:0] wb_addr [NPORT];
    logic [XLEN-1:0]          wb_data [NPORT];

    logic [RF_DEPTH-1:0]      sb;

    logic [RF_ADDR_WIDTH-1:0] qry_addr [NQRY];
    logic [NQRY-1:0]          qry_busy;
    logic [NQRY-1:0]          qry_fwd_vld;
    logic [XLEN-1:0]          qry_fwd_data [NQRY];

    // ALU wins a same-rd collision so both ports never hit one register together
    assign collision = alu_vld_i && (alu_rd_i == lsu_rd_i) && (lsu_rd_i != '0);
    assign alu_rdy_o = !wb_hold_i;
    assign lsu_rdy_o = !wb_hold_i && !collision;

    assign in_vld     = {lsu_vld_i, alu_vld_i};
    assign in_rdy     = {lsu_rdy_o, alu_rdy_o};
    assign in_addr[0] = alu_rd_i;
    assign in_addr[1] = lsu_rd_i;
    assign in_data[0] = alu_data_i;
    assign in_data[1] = lsu_data_i;
    assign xfer       = in_vld & in_rdy;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            logic                     vld_reg;
            logic [RF_ADDR_WIDTH-1:0] addr_reg;
            logic [XLEN-1:0]          data_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_reg  <= 1'b0;
                    addr_reg <= '0;
                    data_reg <= '0;
                end else begin
                    vld_reg <= xfer[gi];
                    if (xfer[gi]) begin
                        addr_reg <= in_addr[gi];
                        data_reg <= in_data[gi];
                    end
                end
            end

            // writes to register 0 are accepted but never strobed
            assign wr[gi]      = vld_reg && (addr_reg != '0);
            assign wb_addr[gi] = addr_reg;
            assign wb_data[gi] = data_reg;
        end
    endgenerate

    assign dpu2rf_wr0_o    = wr[0];
    assign dpu2rf_waddr0_o = wb_addr[0];
    assign dpu2rf_wdata0_o = wb_data[0];
    assign dpu2rf_wr1_o    = wr[1];
    assign dpu2rf_waddr1_o = wb_addr[1];
    assign dpu2rf_wdata1_o = wb_data[1];

    assign sb[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < RF_DEPTH; gi++) begin : g_sb
            localparam logic [RF_ADDR_WIDTH-1:0] IDX = RF_ADDR_WIDTH'(gi);
            logic bit_reg;
            logic set_hit;
            logic clr_hit;

            assign set_hit = iss_vld_i && (iss_rd_i == IDX);
            assign clr_hit = (wr[0] && (wb_addr[0] == IDX)) || (wr[1] && (wb_addr[1] == IDX));

            // a fresh issue outranks the write-back retiring the previous producer
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    bit_reg <= 1'b0;
                else if (set_hit)
                    bit_reg <= 1'b1;
                else if (clr_hit)
                    bit_reg <= 1'b0;
            end

            assign sb[gi] = bit_reg;
        end
    endgenerate

    assign qry_addr[0] = rs1_addr_i;
    assign qry_addr[1] = rs2_addr_i;

    generate
        for (genvar gi = 0; gi < NQRY; gi++) begin : g_qry
            // strobes already exclude register 0, so a zero query never matches
            always_comb begin
                qry_fwd_vld[gi]  = 1'b0;
                qry_fwd_data[gi] = '0;
                for (int p = NPORT - 1; p >= 0; p--) begin
                    if (wr[p] && (wb_addr[p] == qry_addr[gi])) begin
                        qry_fwd_vld[gi]  = 1'b1;
                        qry_fwd_data[gi] = wb_data[p];
                    end
                end
            end

            assign qry_busy[gi] = sb[qry_addr[gi]] && !qry_fwd_vld[gi];
        end
    endgenerate

    assign rs1_busy_o     = qry_busy[0];
    assign rs2_busy_o     = qry_busy[1];
    assign rs1_fwd_vld_o  = qry_fwd_vld[0];
    assign rs2_fwd_vld_o  = qry_fwd_vld[1];
    assign rs1_fwd_data_o = qry_fwd_data[0];
    assign rs2_fwd_data_o = qry_fwd_data[1];

    assign idle_o = (sb == '0) && (wr == '0);

endmodule
